// File: rtl/ds1302_pkg.sv
// Shared constants for the DS1302 3-wire read/write engines.
package ds1302_pkg;

  // Bits per command byte and per data byte.
  localparam int NBITS = 8;

  // Engine state encoding.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_SEND_CMD  = 3'd2;
  localparam logic [2:0] ST_RECV_DATA = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;

  // DS1302 register command bytes (bit0 = 1 selects a read).
  localparam logic [7:0] SEC_RD = 8'h81;
  localparam logic [7:0] MIN_RD = 8'h83;
  localparam logic [7:0] HR_RD  = 8'h85;
  localparam logic [7:0] WP_WR  = 8'h8E;

endpackage

// File: rtl/sclk_edge_detect.sv
// Single-clk rise/fall strobes for the slow DS1302 serial clock.
// Shared by the read and write engines.
module sclk_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  output logic rise,
  output logic fall
);

  logic sclk_d;

  // One-clk delayed copy of sclk for edge comparison.
  always_ff @(posedge clk) begin
    if (rst) sclk_d <= 1'b0;
    else     sclk_d <= sclk;
  end

  assign rise = sclk & ~sclk_d;
  assign fall = ~sclk & sclk_d;

endmodule

// File: rtl/ds1302_read.sv
// Single-byte DS1302 register read over the 3-wire bus.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | bus idle, waiting for en; loads the command byte
//   START      | raise ce, take the IO pin, present command bit0
//   SEND_CMD   | new command bit on each sclk fall; release pin on 8th
//   RECV_DATA  | sample IO pin on each sclk rise, LSB first
//   STOP       | ce low, done pulse ends, return to IDLE
import ds1302_pkg::*;

module ds1302_read #(
  parameter int NBITS = ds1302_pkg::NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NBITS-1:0] addr,
  input  logic             sclk,
  input  logic             dataIn,
  output logic             ce,
  output logic             dataOut,
  output logic             ioDir,
  output logic [NBITS-1:0] dataRead,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

  logic [2:0]       state;
  logic [NBITS-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             sclk_rise;
  logic             sclk_fall;

  sclk_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  assign busy = (state != ST_IDLE);

  // Transaction sequencer: command shift-out on falls, data shift-in on rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ce        <= 1'b0;
      dataOut   <= 1'b0;
      ioDir     <= 1'b0;
      dataRead  <= '0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ce      <= 1'b0;
          ioDir   <= 1'b0;
          done    <= 1'b0;
          bit_cnt <= '0;
          if (en) begin
            shift_reg <= {addr[NBITS-1:1], 1'b1};
            state     <= ST_START;
          end
        end
        ST_START: begin
          ce      <= 1'b1;
          ioDir   <= 1'b1;
          dataOut <= shift_reg[0];
          state   <= ST_SEND_CMD;
        end
        ST_SEND_CMD: begin
          if (sclk_fall) begin
            if (bit_cnt == LAST_BIT) begin
              // Release the pin on the last fall so the DS1302 can drive data bit0.
              ioDir     <= 1'b0;
              bit_cnt   <= '0;
              shift_reg <= '0;
              state     <= ST_RECV_DATA;
            end else begin
              shift_reg <= shift_reg >> 1;
              dataOut   <= shift_reg[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        ST_RECV_DATA: begin
          if (sclk_rise) begin
            shift_reg <= {dataIn, shift_reg[NBITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              dataRead <= {dataIn, shift_reg[NBITS-1:1]};
              ce       <= 1'b0;
              done     <= 1'b1;
              state    <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          ce    <= 1'b0;
          ioDir <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds1302_read.sv
// Bench for ds1302_read: behavioural DS1302 model with a register array,
// sclk generator that runs only while ce is high, and bus monitors.
module tb_ds1302_read;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] addr;
  logic       sclk;
  logic       dataIn;
  logic       ce;
  logic       dataOut;
  logic       ioDir;
  logic [7:0] dataRead;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  ds1302_read dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .addr     (addr),
    .sclk     (sclk),
    .dataIn   (dataIn),
    .ce       (ce),
    .dataOut  (dataOut),
    .ioDir    (ioDir),
    .dataRead (dataRead),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // sclk divider: idles low, toggles every HALF clks while ce is high.
  int sc_cnt;
  initial begin
    sclk   = 1'b0;
    sc_cnt = 0;
    forever begin
      @(negedge clk);
      if (ce !== 1'b1) begin
        sclk   = 1'b0;
        sc_cnt = 0;
      end else begin
        sc_cnt++;
        if (sc_cnt == HALF) begin
          sclk   = ~sclk;
          sc_cnt = 0;
        end
      end
    end
  end

  // DS1302 model: latch command on first 8 rises, then drive data on falls.
  logic [7:0] ds_mem [32];
  logic       m_sclk_d = 1'b0;
  int         m_rise = 0;
  int         m_dfall = 0;
  logic [7:0] m_cmd = 8'h00;
  logic       m_drive = 1'b0;
  logic       m_bit = 1'b0;
  int         dir_err = 0;

  assign dataIn = m_drive ? m_bit : 1'b0;

  always @(posedge clk) begin
    m_sclk_d <= sclk;
    if (rst === 1'b1 || ce !== 1'b1) begin
      m_rise  <= 0;
      m_dfall <= 0;
      m_drive <= 1'b0;
      m_bit   <= 1'b0;
    end else begin
      if (sclk && !m_sclk_d) begin
        if (m_rise < 8) begin
          m_cmd[m_rise[2:0]] <= dataOut;
          if (ioDir !== 1'b1) dir_err <= dir_err + 1;
        end
        m_rise <= m_rise + 1;
      end
      if (!sclk && m_sclk_d && m_rise >= 8 && m_dfall < 8) begin
        m_drive <= 1'b1;
        m_bit   <= ds_mem[m_cmd[5:1]][m_dfall[2:0]];
        m_dfall <= m_dfall + 1;
      end
    end
  end

  // Bus monitors: contention, done width/count, ce low gap, transaction starts.
  int   contention = 0;
  int   done_cnt = 0;
  int   done_wide = 0;
  logic done_prev = 1'b0;
  int   ce_starts = 0;
  logic ce_prev = 1'b0;
  int   low_run = 0;
  int   min_gap = 1000;
  logic seen_high = 1'b0;

  always @(negedge clk) begin
    if (ioDir === 1'b1 && m_drive) contention++;
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) done_wide++;
    end
    done_prev = (done === 1'b1);
    if (ce === 1'b1 && !ce_prev) begin
      ce_starts++;
      if (seen_high && low_run < min_gap) min_gap = low_run;
    end
    if (ce === 1'b1) begin
      low_run   = 0;
      seen_high = 1'b1;
    end else begin
      low_run++;
    end
    ce_prev = (ce === 1'b1);
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(32'(n < 2000), 32'd1, {tag, "_done_timeout"});
  endtask

  task automatic run_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    int d0;
    int s0;
    logic [7:0] exp_cmd;
    exp_cmd = {a[7:1], 1'b1};
    d0 = done_cnt;
    s0 = ce_starts;
    @(negedge clk);
    addr = a;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk(32'(busy), 32'd1, {tag, "_busy"});
    wait_done(tag);
    chk(32'(dataRead), 32'(exp), {tag, "_data"});
    chk(32'(m_cmd), 32'(exp_cmd), {tag, "_cmd"});
    repeat (4) @(negedge clk);
    chk(32'(done_cnt - d0), 32'd1, {tag, "_done_count"});
    chk(32'(ce_starts - s0), 32'd1, {tag, "_txn_count"});
    chk(32'(ce), 32'd0, {tag, "_ce_low"});
    chk(32'(busy), 32'd0, {tag, "_idle"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int s0;
    int n;
    logic [7:0] a;

    rst  = 1'b1;
    en   = 1'b0;
    addr = 8'h00;
    for (int i = 0; i < 32; i++) ds_mem[i] = 8'($urandom);
    ds_mem[0] = 8'h59;
    ds_mem[1] = 8'h45;
    ds_mem[2] = 8'h23;
    ds_mem[3] = 8'hA5;
    repeat (3) @(negedge clk);
    chk(32'(ce), 32'd0, "rst_ce");
    chk(32'(dataOut), 32'd0, "rst_dataOut");
    chk(32'(ioDir), 32'd0, "rst_ioDir");
    chk(32'(dataRead), 32'h00, "rst_dataRead");
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(done), 32'd0, "rst_done");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Seconds read.
    run_read(8'h81, 8'h59, "sec_rd");

    // Read bit clear in addr still issues a read command.
    ds_mem[0] = 8'h12;
    run_read(8'h80, 8'h12, "rd_bit_forced");
    ds_mem[0] = 8'h59;

    // en pulsed repeatedly while busy is ignored.
    d0 = done_cnt;
    s0 = ce_starts;
    @(negedge clk);
    addr = 8'h83;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (6) begin
      repeat (12) @(negedge clk);
      addr = 8'h85;
      en   = 1'b1;
      @(negedge clk);
      en = 1'b0;
    end
    wait_done("en_busy");
    chk(32'(dataRead), 32'h45, "en_busy_data");
    chk(32'(m_cmd), 32'h83, "en_busy_cmd");
    repeat (4) @(negedge clk);
    chk(32'(done_cnt - d0), 32'd1, "en_busy_done_count");
    chk(32'(ce_starts - s0), 32'd1, "en_busy_txn_count");

    // Reset at the 3rd data rise after a completed read.
    run_read(8'h87, 8'hA5, "pre_abort");
    d0 = done_cnt;
    @(negedge clk);
    addr = 8'h85;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n  = 0;
    while (m_rise != 11 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(32'(n < 2000), 32'd1, "abort_wait_timeout");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(32'(ce), 32'd0, "abort_ce");
    chk(32'(ioDir), 32'd0, "abort_ioDir");
    chk(32'(busy), 32'd0, "abort_busy");
    chk(32'(dataRead), 32'h00, "abort_dataRead");
    repeat (40) @(negedge clk);
    chk(32'(done_cnt - d0), 32'd0, "abort_no_done");
    run_read(8'h85, 8'h23, "post_abort");

    // Back-to-back reads with en held high.
    min_gap = 1000;
    d0 = done_cnt;
    @(negedge clk);
    addr = 8'h81;
    en   = 1'b1;
    wait_done("b2b_first");
    chk(32'(dataRead), 32'h59, "b2b_first_data");
    addr = 8'h83;
    @(negedge clk);
    wait_done("b2b_second");
    chk(32'(dataRead), 32'h45, "b2b_second_data");
    chk(32'(m_cmd), 32'h83, "b2b_second_cmd");
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk(32'(done_cnt - d0), 32'd2, "b2b_done_count");
    chk(32'(min_gap >= 2), 32'd1, "b2b_ce_gap");

    // Randomized addresses against the model register array.
    repeat (6) begin
      a = 8'($urandom);
      ds_mem[a[5:1]] = 8'($urandom);
      run_read(a, ds_mem[a[5:1]], "rand");
    end

    chk(32'(contention), 32'd0, "bus_contention");
    chk(32'(dir_err), 32'd0, "cmd_ioDir");
    chk(32'(done_wide), 32'd0, "done_width");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
